// File: rtl/wb_bfm_arbiter_pkg.sv
// Package: wb_bfm_arbiter_pkg
// Purpose : Shared types for the Wishbone round-robin arbiter. It holds the
//           Wishbone B3 cycle-type (CTI) and burst-type (BTE) codes, the
//           arbiter state encoding, and a modular-add helper used by the
//           round-robin picker.
// Ports   : none (package)
package wb_bfm_arbiter_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_END     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // (a + b) mod n, assuming a < n and b <= n
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/wb_bfm_arbiter_if.sv
// Interface: wb_bfm_arbiter_if
// Purpose  : Bundles the master-side (wbm_*) and slave-side (wbs_*) Wishbone
//            signals of the arbiter plus the debug grant vector.
// Modports : slave  - the arbiter's view (accepts master requests, drives the
//                     shared slave port and routes responses back)
//            master - the environment's view (masters and the slave device)
// Signals  : wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  packed per master
//            wbm_dat_o (broadcast), wbm_ack_o/err_o/rty_o (per master)
//            wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  slave request
//            wbs_dat_i/ack_i/err_i/rty_i  slave response, grant_o one-hot grant
interface wb_bfm_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int aw          = 32,
    parameter int dw          = 32
);
    logic [NUM_MASTERS*aw-1:0] wbm_adr_i;
    logic [NUM_MASTERS*dw-1:0] wbm_dat_i;
    logic [NUM_MASTERS*4-1:0]  wbm_sel_i;
    logic [NUM_MASTERS-1:0]    wbm_we_i;
    logic [NUM_MASTERS-1:0]    wbm_cyc_i;
    logic [NUM_MASTERS-1:0]    wbm_stb_i;
    logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
    logic [dw-1:0]             wbm_dat_o;
    logic [NUM_MASTERS-1:0]    wbm_ack_o;
    logic [NUM_MASTERS-1:0]    wbm_err_o;
    logic [NUM_MASTERS-1:0]    wbm_rty_o;
    logic [aw-1:0]             wbs_adr_o;
    logic [dw-1:0]             wbs_dat_o;
    logic [3:0]                wbs_sel_o;
    logic                      wbs_we_o;
    logic                      wbs_cyc_o;
    logic                      wbs_stb_o;
    logic [2:0]                wbs_cti_o;
    logic [1:0]                wbs_bte_o;
    logic [dw-1:0]             wbs_dat_i;
    logic                      wbs_ack_i;
    logic                      wbs_err_i;
    logic                      wbs_rty_i;
    logic [NUM_MASTERS-1:0]    grant_o;

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output grant_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  grant_o
    );
endinterface

// File: rtl/wb_bfm_arbiter_rr_pick.sv
// Module : wb_bfm_arbiter_rr_pick
// Purpose: Combinational round-robin pick. The request vector is rotated so
//          that index last+1 lands at bit 0, the lowest set bit is found, and
//          the result is rotated back to an absolute master index.
// Ports  : i_req   requests, one bit per master
//          i_last  index of the previous winner (lowest priority)
//          o_grant one-hot winner, o_idx winner index, o_valid any request
module wb_bfm_arbiter_rr_pick
    import wb_bfm_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]         i_req,
    input  logic [$clog2(NUM_MASTERS)-1:0] i_last,
    output logic [NUM_MASTERS-1:0]         o_grant,
    output logic [$clog2(NUM_MASTERS)-1:0] o_idx,
    output logic                           o_valid
);
    localparam int LW = $clog2(NUM_MASTERS);

    logic [LW-1:0]            w_start;
    logic [LW:0]              w_base;
    logic [2*NUM_MASTERS-1:0] w_dbl;
    logic [NUM_MASTERS-1:0]   w_rot;
    logic [LW-1:0]            w_off;

    // rotate: doubling the vector turns the circular shift into a part-select
    always_comb begin
        w_start = LW'(wrap_add(int'(i_last), 32'd1, NUM_MASTERS));
        w_base  = {1'b0, w_start};
        w_dbl   = {i_req, i_req};
        w_rot   = w_dbl[w_base +: NUM_MASTERS];
    end

    // priority-encode the lowest set bit of the rotated vector
    always_comb begin
        w_off   = {LW{1'b0}};
        o_valid = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off   = LW'(i);
                o_valid = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

    // unrotate back to an absolute index and one-hot grant
    always_comb begin
        o_idx = LW'(wrap_add(int'(w_off), int'(w_start), NUM_MASTERS));
        if (o_valid) begin
            o_grant = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << o_idx;
        end else begin
            o_grant = {NUM_MASTERS{1'b0}};
        end
    end
endmodule

// File: rtl/wb_bfm_arbiter.sv
// Module : wb_bfm_arbiter
// Purpose: Round-robin arbiter sharing one Wishbone B3 slave port among
//          NUM_MASTERS masters. A grant is held for the whole wb_cyc cycle so
//          bursts are never split. On release the next requester is chosen in
//          the same edge, so hand-over costs only the owner's own low cycle.
// Ports  : wb_clk_i  clock (rising edge), wb_rst_i async active-high reset
//          bus       wb_bfm_arbiter_if.slave (master requests, slave port,
//                    routed responses, grant_o)
// Config : WB_ARB_TIMEOUT_EN - adds a watchdog that errors the owner after
//          TIMEOUT strobe clocks without a slave response, forces the slave
//          cyc/stb low and ignores the slave until the owner drops cyc.
module wb_bfm_arbiter
    import wb_bfm_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int aw          = 32,
    parameter int dw          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_bfm_arbiter_if.slave    bus
);
    localparam int LW = $clog2(NUM_MASTERS);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [LW-1:0]          r_gidx;
    logic [LW-1:0]          r_last;

    logic                   w_owned;
    logic                   w_owner_cyc;
    logic                   w_owner_stb;
    logic [LW-1:0]          w_pick_last;
    logic [NUM_MASTERS-1:0] w_pick_grant;
    logic [LW-1:0]          w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_block;
    logic                   w_to_err;

    // owner status; on release the owner itself becomes the lowest priority
    always_comb begin
        w_owned     = (r_state == ST_OWNED);
        w_owner_cyc = w_owned & bus.wbm_cyc_i[r_gidx];
        w_owner_stb = w_owned & bus.wbm_stb_i[r_gidx];
        if (w_owned) begin
            w_pick_last = r_gidx;
        end else begin
            w_pick_last = r_last;
        end
    end

    wb_bfm_arbiter_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .i_req   (bus.wbm_cyc_i),
        .i_last  (w_pick_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // grant/last registers and the IDLE/OWNED state machine
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_grant <= {NUM_MASTERS{1'b0}};
            r_gidx  <= {LW{1'b0}};
            r_last  <= LW'(NUM_MASTERS - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= ST_OWNED;
                        r_grant <= w_pick_grant;
                        r_gidx  <= w_pick_idx;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OWNED: begin
                    if (!w_owner_cyc) begin
                        // release edge: hand over directly when someone waits
                        r_last <= r_gidx;
                        if (w_pick_valid) begin
                            r_grant <= w_pick_grant;
                            r_gidx  <= w_pick_idx;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= {NUM_MASTERS{1'b0}};
                        end
                    end else begin
                        r_state <= ST_OWNED;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= {NUM_MASTERS{1'b0}};
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_wd;
    logic          r_to_err;
    logic          r_timed_out;
    logic          w_resp;

    // any slave response proves the slave is alive
    always_comb begin
        w_resp   = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
        w_block  = r_timed_out;
        w_to_err = r_to_err;
    end

    // watchdog: counts strobe clocks without a response, one-shot err pulse
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wd        <= {CW{1'b0}};
            r_to_err    <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (!w_owner_cyc) begin
            r_wd        <= {CW{1'b0}};
            r_to_err    <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (r_timed_out) begin
            r_wd     <= {CW{1'b0}};
            r_to_err <= 1'b0;
        end else if (w_resp) begin
            r_wd <= {CW{1'b0}};
        end else if (w_owner_stb) begin
            if (r_wd == CW'(TIMEOUT - 1)) begin
                r_wd        <= {CW{1'b0}};
                r_to_err    <= 1'b1;
                r_timed_out <= 1'b1;
            end else begin
                r_wd <= r_wd + CW'(1);
            end
        end else begin
            r_wd <= r_wd;
        end
    end
`else
    logic w_unused_timeout;

    // no watchdog: never block the slave, never inject an error
    always_comb begin
        w_block          = 1'b0;
        w_to_err         = 1'b0;
        w_unused_timeout = (TIMEOUT == 0);
    end
`endif

    // request mux: slave port follows the owner, all zero while idle
    always_comb begin
        bus.wbs_adr_o = {aw{1'b0}};
        bus.wbs_dat_o = {dw{1'b0}};
        bus.wbs_sel_o = 4'b0000;
        bus.wbs_we_o  = 1'b0;
        bus.wbs_cti_o = 3'b000;
        bus.wbs_bte_o = 2'b00;
        bus.wbs_cyc_o = w_owner_cyc & ~w_block;
        bus.wbs_stb_o = w_owner_stb & ~w_block;
        if (w_owned) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (r_gidx == LW'(m)) begin
                    bus.wbs_adr_o = bus.wbm_adr_i[m*aw +: aw];
                    bus.wbs_dat_o = bus.wbm_dat_i[m*dw +: dw];
                    bus.wbs_sel_o = bus.wbm_sel_i[m*4 +: 4];
                    bus.wbs_we_o  = bus.wbm_we_i[m];
                    bus.wbs_cti_o = bus.wbm_cti_i[m*3 +: 3];
                    bus.wbs_bte_o = bus.wbm_bte_i[m*2 +: 2];
                end else begin
                    bus.wbs_we_o = bus.wbs_we_o;
                end
            end
        end else begin
            bus.wbs_we_o = 1'b0;
        end
    end

    // response routing: only the granted master sees ack/err/rty
    always_comb begin
        bus.wbm_dat_o = bus.wbs_dat_i;
        bus.wbm_ack_o = r_grant & {NUM_MASTERS{bus.wbs_ack_i & ~w_block}};
        bus.wbm_err_o = r_grant & {NUM_MASTERS{(bus.wbs_err_i & ~w_block) | w_to_err}};
        bus.wbm_rty_o = r_grant & {NUM_MASTERS{bus.wbs_rty_i & ~w_block}};
        bus.grant_o   = r_grant;
    end
endmodule

// File: tb/tb_wb_bfm_arbiter.sv
// Testbench for wb_bfm_arbiter: directed table of arbitration steps, hand
// sequences for bursts/reset/back-to-back reads, and a randomized run
// checked against a round-robin reference model.
module tb_wb_bfm_arbiter;
    import wb_bfm_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_bfm_arbiter_if #(.NUM_MASTERS(N), .aw(AW), .dw(DW)) bus ();

    wb_bfm_arbiter #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .TIMEOUT(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        mcyc [N];
    logic        mstb [N];
    logic        mwe  [N];
    logic [31:0] madr [N];
    logic [31:0] mdat [N];
    logic [3:0]  msel [N];
    logic [2:0]  mcti [N];
    logic [1:0]  mbte [N];

    typedef struct {
        logic [1:0] cyc;
        logic       ack;
        logic [1:0] exp_grant;
        logic       exp_scyc;
        logic [1:0] exp_ack;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply();
        for (int m = 0; m < N; m++) begin
            bus.wbm_cyc_i[m]          = mcyc[m];
            bus.wbm_stb_i[m]          = mstb[m];
            bus.wbm_we_i[m]           = mwe[m];
            bus.wbm_adr_i[m*AW +: AW] = madr[m];
            bus.wbm_dat_i[m*DW +: DW] = mdat[m];
            bus.wbm_sel_i[m*4 +: 4]   = msel[m];
            bus.wbm_cti_i[m*3 +: 3]   = mcti[m];
            bus.wbm_bte_i[m*2 +: 2]   = mbte[m];
        end
    endtask

    task automatic clear_all();
        for (int m = 0; m < N; m++) begin
            mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0; madr[m] = 32'h0;
            mdat[m] = 32'h0; msel[m] = 4'h0; mcti[m] = 3'b000; mbte[m] = 2'b00;
        end
        apply();
        bus.wbs_dat_i = 32'h0;
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;
        bus.wbs_rty_i = 1'b0;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        mcyc[m] = cyc; mstb[m] = cyc; mwe[m] = we; madr[m] = adr;
        mdat[m] = dat; msel[m] = 4'hF; mcti[m] = cti; mbte[m] = BTE_LINEAR;
        apply();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_all();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int owner;
        int last;
        int c;
        logic [1:0]  e_grant;
        logic [11:0] e_ctl;
        logic [31:0] e_adr, e_wdat, s_dat;
        logic        s_ack, s_err, s_rty;

        tbl[0]  = '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[1]  = '{2'b01, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[2]  = '{2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
        tbl[3]  = '{2'b11, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[4]  = '{2'b10, 1'b0, 2'b10, 1'b1, 2'b00};
        tbl[5]  = '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
        tbl[6]  = '{2'b01, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[7]  = '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[8]  = '{2'b11, 1'b0, 2'b10, 1'b1, 2'b00};
        tbl[9]  = '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
        tbl[10] = '{2'b01, 1'b0, 2'b01, 1'b1, 2'b00};
        tbl[11] = '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00};

        // reset state: outputs stay quiet even with requests and responses present
        rst = 1'b1;
        clear_all();
        set_m(0, 1'b1, 1'b1, 32'h44, 32'h55, CTI_CLASSIC);
        set_m(1, 1'b1, 1'b0, 32'h66, 32'h77, CTI_CLASSIC);
        bus.wbs_ack_i = 1'b1;
        bus.wbs_dat_i = 32'h1234_5678;
        #12;
        chk("rst_grant", bus.grant_o, 2'b00);
        chk("rst_scyc", bus.wbs_cyc_o, 1'b0);
        chk("rst_sstb", bus.wbs_stb_o, 1'b0);
        chk("rst_sadr", bus.wbs_adr_o, 32'h0);
        chk("rst_ack", bus.wbm_ack_o, 2'b00);
        chk("rst_rdat", bus.wbm_dat_o, 32'h1234_5678);
        clear_all();
        @(negedge clk);
        rst = 1'b0;

        // single write from m0
        @(negedge clk);
        set_m(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, CTI_CLASSIC);
        #1;
        chk("t1_grant_pre", bus.grant_o, 2'b00);
        chk("t1_scyc_pre", bus.wbs_cyc_o, 1'b0);
        @(posedge clk); #1;
        chk("t1_grant", bus.grant_o, 2'b01);
        chk("t1_scyc", bus.wbs_cyc_o, 1'b1);
        chk("t1_sadr", bus.wbs_adr_o, 32'h100);
        chk("t1_sdat", bus.wbs_dat_o, 32'hDEAD_BEEF);
        chk("t1_swe_sel", {bus.wbs_we_o, bus.wbs_sel_o}, 5'b1_1111);
        @(negedge clk);
        bus.wbs_ack_i = 1'b1;
        #1;
        chk("t1_ack", bus.wbm_ack_o, 2'b01);
        @(negedge clk);
        bus.wbs_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        @(posedge clk); #1;
        chk("t1_release", bus.grant_o, 2'b00);

        // arbitration table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            for (int m = 0; m < N; m++) begin
                mcyc[m] = tbl[i].cyc[m];
                mstb[m] = tbl[i].cyc[m];
            end
            apply();
            bus.wbs_ack_i = tbl[i].ack;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_grant", i), bus.grant_o, tbl[i].exp_grant);
            chk($sformatf("tbl%0d_scyc", i), bus.wbs_cyc_o, tbl[i].exp_scyc);
            chk($sformatf("tbl%0d_ack", i), bus.wbm_ack_o, tbl[i].exp_ack);
        end
        clear_all();

        // 8-beat INCR burst by m0, m1 requests at beat 2
        @(negedge clk);
        set_m(0, 1'b1, 1'b0, 32'h0, 32'h0, CTI_INCR);
        @(posedge clk); #1;
        chk("t3_grant0", bus.grant_o, 2'b01);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            set_m(0, 1'b1, 1'b0, 32'(b * 4), 32'h0, (b == 7) ? CTI_END : CTI_INCR);
            if (b == 2) set_m(1, 1'b1, 1'b0, 32'h300, 32'h0, CTI_CLASSIC);
            bus.wbs_ack_i = 1'b1;
            #1;
            chk($sformatf("t3_ack_b%0d", b), bus.wbm_ack_o, 2'b01);
            chk($sformatf("t3_adr_b%0d", b), bus.wbs_adr_o, 32'(b * 4));
            @(posedge clk); #1;
            chk($sformatf("t3_grant_b%0d", b), bus.grant_o, 2'b01);
        end
        @(negedge clk);
        bus.wbs_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        #1;
        chk("t3_owner_low", bus.wbs_cyc_o, 1'b0);
        @(posedge clk); #1;
        chk("t3_handover", bus.grant_o, 2'b10);
        chk("t3_handover_cyc", bus.wbs_cyc_o, 1'b1);
        @(negedge clk);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        @(posedge clk);

        // back-to-back single reads by m1, m0 idle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_m(1, 1'b1, 1'b0, 32'(32'h200 + k * 4), 32'h0, CTI_CLASSIC);
            @(posedge clk); #1;
            chk($sformatf("t4_grant%0d", k), bus.grant_o, 2'b10);
            @(negedge clk);
            bus.wbs_ack_i = 1'b1;
            bus.wbs_dat_i = 32'(32'h1000 + k);
            #1;
            chk($sformatf("t4_ack%0d", k), bus.wbm_ack_o, 2'b10);
            chk($sformatf("t4_rdat%0d", k), bus.wbm_dat_o, 32'(32'h1000 + k));
            @(negedge clk);
            bus.wbs_ack_i = 1'b0;
            set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        end

        // asynchronous reset during beat 3 of a burst
        @(negedge clk);
        set_m(0, 1'b1, 1'b0, 32'h0, 32'h0, CTI_INCR);
        set_m(1, 1'b1, 1'b0, 32'h400, 32'h0, CTI_CLASSIC);
        @(posedge clk); #1;
        chk("t5_grant", bus.grant_o, 2'b01);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            set_m(0, 1'b1, 1'b0, 32'(b * 4), 32'h0, CTI_INCR);
            bus.wbs_ack_i = 1'b1;
            if (b < 3) @(posedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_scyc", bus.wbs_cyc_o, 1'b0);
        chk("t5_rst_grant", bus.grant_o, 2'b00);
        chk("t5_rst_ack", bus.wbm_ack_o, 2'b00);
        bus.wbs_ack_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_after_rst", bus.grant_o, 2'b01);

`ifdef WB_ARB_TIMEOUT_EN
        begin
            int  cnt;
            bit  seen;
            do_reset();
            @(negedge clk);
            set_m(0, 1'b1, 1'b0, 32'h800, 32'h0, CTI_CLASSIC);
            set_m(1, 1'b1, 1'b0, 32'h900, 32'h0, CTI_CLASSIC);
            cnt = 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clk); #1;
                if (bus.wbm_err_o[0]) seen = 1'b1;
                else if (bus.wbs_stb_o) cnt++;
            end
            chk("t6_err_seen", seen, 1'b1);
            chk("t6_stb_clocks", cnt, 16);
            chk("t6_cyc_forced", bus.wbs_cyc_o, 1'b0);
            @(posedge clk); #1;
            chk("t6_err_pulse", bus.wbm_err_o, 2'b00);
            chk("t6_cyc_held", bus.wbs_cyc_o, 1'b0);
            @(negedge clk);
            set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
            @(posedge clk); #1;
            chk("t6_next", bus.grant_o, 2'b10);
        end
`endif

        // randomized traffic against the round-robin reference model
        do_reset();
        owner = -1;
        last  = N - 1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            for (int m = 0; m < N; m++) begin
                if (mcyc[m]) begin
                    // non-owners must hold; the owner sometimes ends its cycle
                    mcyc[m] = !(m == owner && $urandom_range(0, 3) == 0);
                end else begin
                    mcyc[m] = ($urandom_range(0, 1) == 1);
                end
                mstb[m] = mcyc[m] && ($urandom_range(0, 3) != 0);
                mwe[m]  = ($urandom_range(0, 1) == 1);
                madr[m] = $urandom;
                mdat[m] = $urandom;
                msel[m] = 4'($urandom_range(0, 15));
                mcti[m] = 3'($urandom_range(0, 7));
                mbte[m] = 2'($urandom_range(0, 3));
            end
            apply();
            s_ack = ($urandom_range(0, 3) == 0);
            s_err = ($urandom_range(0, 3) == 0);
            s_rty = ($urandom_range(0, 3) == 0);
            s_dat = $urandom;
            bus.wbs_ack_i = s_ack;
            bus.wbs_err_i = s_err;
            bus.wbs_rty_i = s_rty;
            bus.wbs_dat_i = s_dat;
            #1;
            if (owner >= 0) begin
                e_grant = 2'(1 << owner);
                e_ctl   = {mcyc[owner], mstb[owner], mwe[owner], msel[owner], mcti[owner], mbte[owner]};
                e_adr   = madr[owner];
                e_wdat  = mdat[owner];
            end else begin
                e_grant = 2'b00;
                e_ctl   = 12'h000;
                e_adr   = 32'h0;
                e_wdat  = 32'h0;
            end
            chk("rnd_grant", bus.grant_o, e_grant);
            chk("rnd_ctl", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_sel_o,
                            bus.wbs_cti_o, bus.wbs_bte_o}, e_ctl);
            chk("rnd_adr", bus.wbs_adr_o, e_adr);
            chk("rnd_wdat", bus.wbs_dat_o, e_wdat);
            chk("rnd_ack", bus.wbm_ack_o, s_ack ? e_grant : 2'b00);
            chk("rnd_err", bus.wbm_err_o, s_err ? e_grant : 2'b00);
            chk("rnd_rty", bus.wbm_rty_o, s_rty ? e_grant : 2'b00);
            chk("rnd_rdat", bus.wbm_dat_o, s_dat);
            @(posedge clk);
            if (owner >= 0 && !mcyc[owner]) begin
                last  = owner;
                owner = -1;
            end
            if (owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (last + k) % N;
                    if (owner < 0 && mcyc[c]) owner = c;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
